// File: rtl/sysid_boot_sequencer.sv
// Boot sequencer: reads the sysid slave (ID, then timestamp) after reset, checks the
// build-time ID and keeps the CPU core in reset until the check passes, with bounded retries.
module sysid_boot_sequencer #(
   parameter logic [31:0] EXPECTED_ID    = 32'h63BA_7091,
   parameter int unsigned STARTUP_DELAY  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter bit          CHECK_TS       = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        cpu_reset,
   output logic        done,
   output logic        id_ok,
   output logic        mismatch_err,
   output logic        timeout_err,
   output logic [1:0]  retry_count,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int DLY_W = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [DLY_W-1:0] DLY_LAST    = DLY_W'(STARTUP_DELAY - 1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       MAX_RETRY_L = 2'(MAX_RETRIES);

   localparam logic [2:0] ST_WAIT  = 3'd0;
   localparam logic [2:0] ST_RD_ID = 3'd1;
   localparam logic [2:0] ST_RD_TS = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_RETRY = 3'd4;
   localparam logic [2:0] ST_PASS  = 3'd5;
   localparam logic [2:0] ST_FAIL  = 3'd6;

   logic [2:0]       r_state;
   logic [DLY_W-1:0] r_delay_cnt;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_read;
   logic             r_address;
   logic             r_cpu_reset;
   logic             r_done;
   logic             r_id_ok;
   logic             r_mismatch_err;
   logic             r_timeout_err;
   logic [1:0]       r_retry_count;
   logic [31:0]      r_id_value;
   logic [31:0]      r_ts_value;

   logic             w_check_pass;
   logic             w_tmo_hit;

   assign w_check_pass = (r_id_value == EXPECTED_ID) && (!CHECK_TS || (r_ts_value != 32'd0));
   assign w_tmo_hit    = avm_waitrequest && (r_tmo_cnt == TMO_LAST);

   // NOTE: all state below is sequential, so every assignment uses <= to keep
   // updates simultaneous at the edge regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_WAIT;
         r_delay_cnt    <= '0;
         r_tmo_cnt      <= '0;
         r_read         <= 1'b0;
         r_address      <= 1'b0;
         r_cpu_reset    <= 1'b1;
         r_done         <= 1'b0;
         r_id_ok        <= 1'b0;
         r_mismatch_err <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_retry_count  <= 2'd0;
         r_id_value     <= 32'd0;
         r_ts_value     <= 32'd0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (r_delay_cnt == DLY_LAST) begin
                  r_state     <= ST_RD_ID;
                  r_delay_cnt <= '0;
                  r_tmo_cnt   <= '0;
                  r_read      <= 1'b1;
                  r_address   <= 1'b0;
               end else begin
                  r_delay_cnt <= r_delay_cnt + 1'b1;
               end
            end

            ST_RD_ID: begin
               if (!avm_waitrequest) begin
                  r_id_value <= avm_readdata;
                  r_state    <= ST_RD_TS;
                  r_address  <= 1'b1;
                  r_tmo_cnt  <= '0;
               end else if (w_tmo_hit) begin
                  r_read         <= 1'b0;
                  r_timeout_err  <= 1'b1;
                  r_mismatch_err <= 1'b0;
                  r_tmo_cnt      <= '0;
                  r_state        <= ST_RETRY;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end

            ST_RD_TS: begin
               if (!avm_waitrequest) begin
                  r_ts_value <= avm_readdata;
                  r_read     <= 1'b0;
                  r_address  <= 1'b0;
                  r_tmo_cnt  <= '0;
                  r_state    <= ST_CHECK;
               end else if (w_tmo_hit) begin
                  r_read         <= 1'b0;
                  r_address      <= 1'b0;
                  r_timeout_err  <= 1'b1;
                  r_mismatch_err <= 1'b0;
                  r_tmo_cnt      <= '0;
                  r_state        <= ST_RETRY;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end

            ST_CHECK: begin
               if (w_check_pass) begin
                  r_state <= ST_PASS;
               end else begin
                  r_mismatch_err <= 1'b1;
                  r_timeout_err  <= 1'b0;
                  r_state        <= ST_RETRY;
               end
            end

            // Error flags are left alone here so they describe the last failure.
            ST_RETRY: begin
               if (r_retry_count < MAX_RETRY_L) begin
                  r_retry_count <= r_retry_count + 1'b1;
                  r_delay_cnt   <= '0;
                  r_state       <= ST_WAIT;
               end else begin
                  r_state <= ST_FAIL;
               end
            end

            ST_PASS: begin
               r_cpu_reset    <= 1'b0;
               r_id_ok        <= 1'b1;
               r_done         <= 1'b1;
               r_mismatch_err <= 1'b0;
               r_timeout_err  <= 1'b0;
            end

            ST_FAIL: begin
               r_cpu_reset <= 1'b1;
               r_id_ok     <= 1'b0;
               r_done      <= 1'b1;
            end

            default: begin
               r_state <= ST_WAIT;
               r_read  <= 1'b0;
            end
         endcase
      end
   end

   assign avm_address  = r_address;
   assign avm_read     = r_read;
   assign cpu_reset    = r_cpu_reset;
   assign done         = r_done;
   assign id_ok        = r_id_ok;
   assign mismatch_err = r_mismatch_err;
   assign timeout_err  = r_timeout_err;
   assign retry_count  = r_retry_count;
   assign id_value     = r_id_value;
   assign ts_value     = r_ts_value;

endmodule

// File: tb/tb_sysid_boot_sequencer.sv
// Bench for sysid_boot_sequencer: a scripted sysid slave plus an attempt-level model
// predicting outcome, captured values and the cycle at which done rises.
module tb_sysid_boot_sequencer;

   localparam logic [31:0] EXP_ID = 32'h63BA_7091;
   localparam int D       = 16;
   localparam int T       = 64;
   localparam int MAXR    = 3;
   localparam int NATT    = MAXR + 1;
   localparam int STUCK   = 1000;
   localparam int BUDGET  = 3000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata = 32'd0;
   logic        avm_waitrequest = 1'b0;
   logic        cpu_reset;
   logic        done;
   logic        id_ok;
   logic        mismatch_err;
   logic        timeout_err;
   logic [1:0]  retry_count;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   sysid_boot_sequencer dut (
      .clock           (clock),
      .reset           (reset),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .cpu_reset       (cpu_reset),
      .done            (done),
      .id_ok           (id_ok),
      .mismatch_err    (mismatch_err),
      .timeout_err     (timeout_err),
      .retry_count     (retry_count),
      .id_value        (id_value),
      .ts_value        (ts_value)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Per-attempt slave script: data returned and stall cycles for each read.
   logic [31:0] id_val   [NATT];
   logic [31:0] ts_val   [NATT];
   int          id_stall [NATT];
   int          ts_stall [NATT];

   int  nid, cur, stall_left;
   bit  in_txn;
   bit  p_read, p_wait, p_addr;
   int  addr_viol = 0;
   int  read_viol = 0;

   // Slave reacts just after each edge to the registered master outputs.
   always @(posedge clock) begin
      #1;
      if (!reset && p_read && p_wait && avm_read && (avm_address != p_addr)) addr_viol++;
      if (!reset && done && avm_read) read_viol++;
      if (reset) begin
         nid = 0; cur = 0; in_txn = 0; stall_left = 0;
         avm_waitrequest = 1'b0;
      end else if (avm_read) begin
         if (!in_txn) begin
            in_txn = 1;
            if (!avm_address) begin
               cur = nid; nid++;
               stall_left = id_stall[cur];
            end else begin
               stall_left = ts_stall[cur];
            end
         end
         if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
            stall_left--;
         end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = avm_address ? ts_val[cur] : id_val[cur];
            in_txn = 0;
         end
      end else begin
         in_txn = 0;
         avm_waitrequest = 1'($urandom_range(0, 1));
         avm_readdata    = $urandom;
      end
      p_read = avm_read;
      p_addr = avm_address;
      p_wait = avm_waitrequest;
   end

   // Attempt-level model: each attempt is delay + read lengths + check/retry cycles.
   task automatic model(output int t, output bit pass, output bit mm, output bit to,
                        output int rc, output logic [31:0] idv, output logic [31:0] tsv);
      t = 0; pass = 0; mm = 0; to = 0; rc = 0; idv = 32'd0; tsv = 32'd0;
      for (int a = 0; a < NATT; a++) begin
         bit ok;
         ok = 0;
         t += D;
         if (id_stall[a] >= T) begin
            t += T; to = 1; mm = 0;
         end else begin
            t += id_stall[a] + 1;
            idv = id_val[a];
            if (ts_stall[a] >= T) begin
               t += T; to = 1; mm = 0;
            end else begin
               t += ts_stall[a] + 1;
               tsv = ts_val[a];
               t += 1;
               if (idv == EXP_ID) ok = 1;
               else begin mm = 1; to = 0; end
            end
         end
         if (ok) begin
            t += 1; pass = 1; mm = 0; to = 0; rc = a;
            break;
         end
         t += 1;
         if (a == MAXR) begin
            t += 1; rc = a;
         end
      end
   endtask

   task automatic set_att(input int a, input logic [31:0] idv, input int is,
                          input logic [31:0] tsv, input int tss);
      id_val[a] = idv; id_stall[a] = is; ts_val[a] = tsv; ts_stall[a] = tss;
   endtask

   task automatic set_all(input logic [31:0] idv, input int is, input logic [31:0] tsv, input int tss);
      for (int a = 0; a < NATT; a++) set_att(a, idv, is, tsv, tss);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "/rst_read"},  32'(avm_read),     32'd0);
      check({tag, "/rst_addr"},  32'(avm_address),  32'd0);
      check({tag, "/rst_cpu"},   32'(cpu_reset),    32'd1);
      check({tag, "/rst_done"},  32'(done),         32'd0);
      check({tag, "/rst_idok"},  32'(id_ok),        32'd0);
      check({tag, "/rst_mm"},    32'(mismatch_err), 32'd0);
      check({tag, "/rst_to"},    32'(timeout_err),  32'd0);
      check({tag, "/rst_rc"},    32'(retry_count),  32'd0);
      check({tag, "/rst_id"},    id_value,          32'd0);
      check({tag, "/rst_ts"},    ts_value,          32'd0);
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check_reset_vals(tag);
   endtask

   // Releases reset, waits for done and compares the run against the model.
   task automatic run_and_check(input string tag);
      int t, rc, n;
      bit pass, mm, to;
      logic [31:0] idv, tsv;
      model(t, pass, mm, to, rc, idv, tsv);
      addr_viol = 0;
      read_viol = 0;
      reset = 1'b0;
      n = 0;
      while (n < BUDGET) begin
         @(negedge clock);
         n++;
         if (done) break;
      end
      check({tag, "/latency"}, 32'(n),            32'(t));
      check({tag, "/done"},    32'(done),         32'd1);
      check({tag, "/cpu_rst"}, 32'(cpu_reset),    32'(!pass));
      check({tag, "/id_ok"},   32'(id_ok),        32'(pass));
      check({tag, "/mm_err"},  32'(mismatch_err), 32'(mm));
      check({tag, "/to_err"},  32'(timeout_err),  32'(to));
      check({tag, "/retries"}, 32'(retry_count),  32'(rc));
      check({tag, "/id_val"},  id_value,          idv);
      check({tag, "/ts_val"},  ts_value,          tsv);
      repeat (6) @(negedge clock);
      check({tag, "/sticky"},  {30'd0, done, cpu_reset}, {30'd0, 1'b1, !pass});
      check({tag, "/addr_stable"}, 32'(addr_viol), 32'd0);
      check({tag, "/read_idle"},   32'(read_viol), 32'd0);
   endtask

   function automatic int rand_stall();
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
         5:       return T - 2;
         6:       return T - 1;
         7:       return T;
         8:       return STUCK;
         9:       return int'($urandom_range(4, 10));
         default: return int'($urandom_range(0, 3));
      endcase
   endfunction

   initial begin
      int n;

      // Zero-wait slave, correct ID: best-case latency.
      set_all(EXP_ID, 0, 32'h5F00_0000, 0);
      apply_reset("zero_wait");
      run_and_check("zero_wait");

      // Five stall cycles on each read.
      set_all(EXP_ID, 5, 32'h5F00_1234, 5);
      apply_reset("stall5");
      run_and_check("stall5");

      // Wrong ID every attempt ends in FAIL after three retries.
      set_all(32'h1234_5678, 0, 32'h0000_0042, 0);
      apply_reset("bad_id");
      run_and_check("bad_id");

      // Waitrequest stuck high: every attempt times out.
      set_all(EXP_ID, STUCK, 32'h1, STUCK);
      apply_reset("stuck");
      run_and_check("stuck");

      // First ID wrong, second correct.
      set_all(EXP_ID, 0, 32'h0BAD_F00D, 0);
      set_att(0, 32'hDEAD_BEEF, 0, 32'h0000_0007, 1);
      apply_reset("retry1");
      run_and_check("retry1");

      // Stall boundaries: T-1 stalls complete, T stalls time out.
      set_all(EXP_ID, 0, 32'hCAFE_0000, 0);
      set_att(0, EXP_ID, T - 1, 32'hCAFE_0001, T);
      set_att(1, EXP_ID, T, 32'hCAFE_0002, 0);
      apply_reset("bound");
      run_and_check("bound");

      // Reset pulsed while RD_TS is stalled.
      set_all(EXP_ID, 0, 32'h7777_0000, STUCK);
      apply_reset("midrd");
      reset = 1'b0;
      n = 0;
      while (n < 200 && !(avm_read && avm_address)) begin
         @(negedge clock);
         n++;
      end
      check("midrd/reached_rd_ts", 32'(avm_read && avm_address), 32'd1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals("midrd_next");
      set_all(EXP_ID, 0, 32'h7777_0001, 2);
      @(negedge clock);
      run_and_check("midrd_restart");

      // Randomized slave behaviour.
      for (int s = 0; s < 12; s++) begin
         for (int a = 0; a < NATT; a++) begin
            logic [31:0] idv, tsv;
            idv = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_ID;
            tsv = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            set_att(a, idv, rand_stall(), tsv, rand_stall());
         end
         apply_reset($sformatf("rand%0d", s));
         run_and_check($sformatf("rand%0d", s));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
